// File: rtl/norm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : norm_ctrl_if
// Description : Column stream from the systolic matmul array into the
//               normalization sequencer (valid/data forward, ready back).
// Revision    : 1.0 - initial release
// ============================================================================
interface norm_ctrl_if #(
    parameter int DWIDTH      = 8,
    parameter int DESIGN_SIZE = 32
);
    logic                            valid;
    logic [DESIGN_SIZE*DWIDTH-1:0]   data;
    logic                            ready;

    // Producer side: the matmul output stage
    modport master (
        output valid,
        output data,
        input  ready
    );

    // Consumer side: the normalization sequencer
    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/norm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : norm_ctrl
// Description : Normalization-stage sequencer. Holds a per-channel
//               mean / inverse-variance table, latches one pair plus the
//               validity mask per tile, streams DESIGN_SIZE columns into
//               norm without gaps, waits for done_norm (with watchdog) and
//               reports completion.
// Revision    : 1.0 - initial release
// ============================================================================
module norm_ctrl #(
    parameter int DWIDTH      = 8,
    parameter int DESIGN_SIZE = 32,
    parameter int MASK_WIDTH  = 32,
    parameter int NUM_CH      = 4,
    parameter int LOG2_NUM_CH = 2,
    parameter int WDOG_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    // parameter-table write port
    input  logic                           cfg_wr_en,
    input  logic [LOG2_NUM_CH-1:0]         cfg_wr_addr,
    input  logic [DWIDTH-1:0]              cfg_wr_mean,
    input  logic [DWIDTH-1:0]              cfg_wr_inv_var,
    // tile command
    input  logic                           start,
    input  logic [LOG2_NUM_CH-1:0]         ch_sel,
    input  logic [MASK_WIDTH-1:0]          mask_in,
    input  logic                           enable_in,
    // matmul column stream
    norm_ctrl_if.slave                     src,
    // to / from norm
    output logic                           norm_enable,
    output logic [DWIDTH-1:0]              norm_mean,
    output logic [DWIDTH-1:0]              norm_inv_var,
    output logic [MASK_WIDTH-1:0]          norm_validity_mask,
    output logic                           norm_in_data_available,
    output logic [DESIGN_SIZE*DWIDTH-1:0]  norm_inp_data,
    input  logic                           norm_done,
    // status
    input  logic                           err_clr,
    output logic                           busy,
    output logic                           done,
    output logic                           err_underrun,
    output logic                           err_timeout
);

    localparam int c_BEAT_W = (DESIGN_SIZE > 1) ? $clog2(DESIGN_SIZE) : 1;
    localparam int c_WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(DESIGN_SIZE - 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ARM    = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                          r_state;
    logic [c_BEAT_W-1:0]             r_beat;
    logic [c_WDOG_W-1:0]             r_wdog;

    // tile command captured in IDLE, consumed by LOAD
    logic [LOG2_NUM_CH-1:0]          r_ch;
    logic [MASK_WIDTH-1:0]           r_mask_cap;
    logic                            r_en_cap;

    logic [DWIDTH-1:0]               r_tbl_mean    [NUM_CH];
    logic [DWIDTH-1:0]               r_tbl_inv_var [NUM_CH];

    logic                            r_norm_enable;
    logic [DWIDTH-1:0]               r_norm_mean;
    logic [DWIDTH-1:0]               r_norm_inv_var;
    logic [MASK_WIDTH-1:0]           r_norm_mask;
    logic                            r_avail;
    logic [DESIGN_SIZE*DWIDTH-1:0]   r_inp_data;
    logic                            r_src_ready;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_err_underrun;
    logic                            r_err_timeout;

    // Parameter table: writable in every state; the active tile is isolated
    // because LOAD copies the entry into the norm_* output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_tbl_mean[i]    <= '0;
                r_tbl_inv_var[i] <= '0;
            end
        end else if (cfg_wr_en) begin
            r_tbl_mean[cfg_wr_addr]    <= cfg_wr_mean;
            r_tbl_inv_var[cfg_wr_addr] <= cfg_wr_inv_var;
        end
    end

    // Tile sequencer with all outputs registered; error sets are written
    // after the clear so that a set wins in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_beat         <= '0;
            r_wdog         <= '0;
            r_ch           <= '0;
            r_mask_cap     <= '0;
            r_en_cap       <= 1'b0;
            r_norm_enable  <= 1'b0;
            r_norm_mean    <= '0;
            r_norm_inv_var <= '0;
            r_norm_mask    <= '0;
            r_avail        <= 1'b0;
            r_inp_data     <= '0;
            r_src_ready    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err_underrun <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            if (err_clr) begin
                r_err_underrun <= 1'b0;
                r_err_timeout  <= 1'b0;
            end
            r_done  <= 1'b0;
            r_avail <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ch       <= ch_sel;
                        r_mask_cap <= mask_in;
                        r_en_cap   <= enable_in;
                        r_busy     <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    // Table read here sees a write made in the start cycle
                    r_norm_mean    <= r_tbl_mean[r_ch];
                    r_norm_inv_var <= r_tbl_inv_var[r_ch];
                    r_norm_mask    <= r_mask_cap;
                    r_norm_enable  <= r_en_cap;
                    r_state        <= S_ARM;
                end

                S_ARM: begin
                    if (src.valid) begin
                        r_beat      <= '0;
                        r_src_ready <= 1'b1;
                        r_state     <= S_STREAM;
                    end
                end

                S_STREAM: begin
                    // Burst never stalls: a missing column becomes zeros
                    r_avail    <= 1'b1;
                    r_inp_data <= src.valid ? src.data : '0;
                    if (!src.valid) begin
                        r_err_underrun <= 1'b1;
                    end
                    if (r_beat == c_LAST_BEAT) begin
                        r_src_ready <= 1'b0;
                        r_wdog      <= '0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (norm_done) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_wdog == c_WDOG_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_done        <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign src.ready              = r_src_ready;
    assign norm_enable            = r_norm_enable;
    assign norm_mean              = r_norm_mean;
    assign norm_inv_var           = r_norm_inv_var;
    assign norm_validity_mask     = r_norm_mask;
    assign norm_in_data_available = r_avail;
    assign norm_inp_data          = r_inp_data;
    assign busy                   = r_busy;
    assign done                   = r_done;
    assign err_underrun           = r_err_underrun;
    assign err_timeout            = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_norm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_norm_ctrl
// Description : Directed self-checking bench for norm_ctrl. Cycle k of a
//               tile is the cycle in which start is presented (k = 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_norm_ctrl;

    localparam int DW = 8;
    localparam int DS = 32;
    localparam int MW = 32;
    localparam int NC = 4;
    localparam int LC = 2;
    localparam int WD = 16;
    localparam int NOBS = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_wr_en;
    logic [LC-1:0]   cfg_wr_addr;
    logic [DW-1:0]   cfg_wr_mean;
    logic [DW-1:0]   cfg_wr_inv_var;
    logic            start;
    logic [LC-1:0]   ch_sel;
    logic [MW-1:0]   mask_in;
    logic            enable_in;
    logic            norm_enable;
    logic [DW-1:0]   norm_mean;
    logic [DW-1:0]   norm_inv_var;
    logic [MW-1:0]   norm_validity_mask;
    logic            norm_in_data_available;
    logic [DS*DW-1:0] norm_inp_data;
    logic            norm_done;
    logic            err_clr;
    logic            busy;
    logic            done;
    logic            err_underrun;
    logic            err_timeout;

    int checks = 0;
    int errors = 0;

    // per-cycle observations of the last tile
    logic             obs_avail [NOBS];
    logic             obs_ready [NOBS];
    logic             obs_busy  [NOBS];
    logic             obs_done  [NOBS];
    logic             obs_en    [NOBS];
    logic             obs_eu    [NOBS];
    logic             obs_et    [NOBS];
    logic [DW-1:0]    obs_mean  [NOBS];
    logic [DW-1:0]    obs_inv   [NOBS];
    logic [MW-1:0]    obs_mask  [NOBS];
    logic [DS*DW-1:0] obs_data  [NOBS];

    norm_ctrl_if #(.DWIDTH(DW), .DESIGN_SIZE(DS)) src_if ();

    norm_ctrl #(
        .DWIDTH(DW), .DESIGN_SIZE(DS), .MASK_WIDTH(MW),
        .NUM_CH(NC), .LOG2_NUM_CH(LC), .WDOG_CYCLES(WD)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .cfg_wr_en              (cfg_wr_en),
        .cfg_wr_addr            (cfg_wr_addr),
        .cfg_wr_mean            (cfg_wr_mean),
        .cfg_wr_inv_var         (cfg_wr_inv_var),
        .start                  (start),
        .ch_sel                 (ch_sel),
        .mask_in                (mask_in),
        .enable_in              (enable_in),
        .src                    (src_if),
        .norm_enable            (norm_enable),
        .norm_mean              (norm_mean),
        .norm_inv_var           (norm_inv_var),
        .norm_validity_mask     (norm_validity_mask),
        .norm_in_data_available (norm_in_data_available),
        .norm_inp_data          (norm_inp_data),
        .norm_done              (norm_done),
        .err_clr                (err_clr),
        .busy                   (busy),
        .done                   (done),
        .err_underrun           (err_underrun),
        .err_timeout            (err_timeout)
    );

    always #5 clk = ~clk;

    // Column presented by the source in tile cycle k
    function automatic logic [DS*DW-1:0] col(input int k);
        logic [DW-1:0] b;
        b = DW'(k + 64);
        return {DS{b}};
    endfunction

    // Drives one tile and records outputs each cycle (sampled 1 time unit
    // after the edge that opens the cycle). done_at: -1 stuck 0, -2 stuck 1.
    task automatic run_tile(input logic [LC-1:0] ch, input logic [MW-1:0] mask,
                            input logic en, input logic [63:0] drop,
                            input int done_at, input int ncyc,
                            input int wr_at = -1, input logic [LC-1:0] wr_ch = '0,
                            input logic [DW-1:0] wr_mean = '0,
                            input logic [DW-1:0] wr_inv = '0,
                            input int start2_at = -1, input int clr_at = -1);
        for (int k = 0; k < ncyc; k++) begin
            int b;
            @(posedge clk); #1;
            obs_avail[k] = norm_in_data_available;
            obs_ready[k] = src_if.ready;
            obs_busy[k]  = busy;
            obs_done[k]  = done;
            obs_en[k]    = norm_enable;
            obs_eu[k]    = err_underrun;
            obs_et[k]    = err_timeout;
            obs_mean[k]  = norm_mean;
            obs_inv[k]   = norm_inv_var;
            obs_mask[k]  = norm_validity_mask;
            obs_data[k]  = norm_inp_data;
            b = k - 3;
            start     = (k == 0) || (k == start2_at);
            ch_sel    = ch;
            mask_in   = mask;
            enable_in = en;
            src_if.valid = !(b >= 0 && b < 64 && drop[b]);
            src_if.data  = col(k);
            cfg_wr_en      = (k == wr_at);
            cfg_wr_addr    = wr_ch;
            cfg_wr_mean    = wr_mean;
            cfg_wr_inv_var = wr_inv;
            err_clr   = (k == clr_at);
            norm_done = (done_at == -2) ? 1'b1 : (k == done_at);
        end
        start = 1'b0; cfg_wr_en = 1'b0; err_clr = 1'b0;
        norm_done = 1'b0; src_if.valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (src_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", src_if.ready); end
        checks++; if (norm_in_data_available !== 1'b0) begin errors++; $display("FAIL reset_avail got %0b exp 0", norm_in_data_available); end
        checks++; if (norm_mean !== 8'h00 || norm_inv_var !== 8'h00) begin errors++; $display("FAIL reset_params got %h/%h exp 00/00", norm_mean, norm_inv_var); end
        checks++; if (norm_validity_mask !== '0 || norm_enable !== 1'b0) begin errors++; $display("FAIL reset_mask_en got %h/%0b exp 0/0", norm_validity_mask, norm_enable); end
        checks++; if (err_underrun !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL reset_errs got %0b%0b exp 00", err_underrun, err_timeout); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        cfg_wr_en = 1'b1; cfg_wr_addr = 2'd2; cfg_wr_mean = 8'h08; cfg_wr_inv_var = 8'h10;
        run_tile(2'd2, '1, 1'b1, 64'd0, 38, 42);
        for (int k = 0; k < 42; k++) begin
            logic ea, er, ed, eb;
            ea = (k >= 4 && k <= 35);
            er = (k >= 3 && k <= 34);
            ed = (k == 39);
            eb = (k >= 1 && k <= 39);
            checks++; if (obs_avail[k] !== ea) begin errors++; $display("FAIL basic_avail k=%0d got %0b exp %0b", k, obs_avail[k], ea); end
            checks++; if (obs_ready[k] !== er) begin errors++; $display("FAIL basic_ready k=%0d got %0b exp %0b", k, obs_ready[k], er); end
            checks++; if (obs_done[k] !== ed) begin errors++; $display("FAIL basic_done k=%0d got %0b exp %0b", k, obs_done[k], ed); end
            checks++; if (obs_busy[k] !== eb) begin errors++; $display("FAIL basic_busy k=%0d got %0b exp %0b", k, obs_busy[k], eb); end
            checks++; if (obs_eu[k] !== 1'b0 || obs_et[k] !== 1'b0) begin errors++; $display("FAIL basic_errs k=%0d got %0b%0b exp 00", k, obs_eu[k], obs_et[k]); end
            if (ea) begin
                checks++; if (obs_data[k] !== col(k - 1)) begin errors++; $display("FAIL basic_data k=%0d got %h exp %h", k, obs_data[k][7:0], col(k - 1)[7:0]); end
            end
            if (k >= 2) begin
                checks++; if (obs_mean[k] !== 8'h08 || obs_inv[k] !== 8'h10) begin errors++; $display("FAIL basic_params k=%0d got %h/%h exp 08/10", k, obs_mean[k], obs_inv[k]); end
                checks++; if (obs_mask[k] !== 32'hFFFF_FFFF || obs_en[k] !== 1'b1) begin errors++; $display("FAIL basic_mask_en k=%0d got %h/%0b exp ffffffff/1", k, obs_mask[k], obs_en[k]); end
            end else if (k == 1) begin
                checks++; if (obs_mean[k] !== 8'h00) begin errors++; $display("FAIL basic_preload k=1 got %h exp 00", obs_mean[k]); end
            end
        end
    endtask

    task automatic test_underrun;
        logic [63:0] drop;
        drop = (64'd1 << 5) | (64'd1 << 6) | (64'd1 << 20);
        // clear requested in the same cycle as the beat-20 underrun
        run_tile(2'd2, '1, 1'b1, drop, 38, 42, -1, 2'd0, 8'h0, 8'h0, -1, 23);
        for (int k = 0; k < 42; k++) begin
            logic ea, eu;
            ea = (k >= 4 && k <= 35);
            eu = (k >= 9);
            checks++; if (obs_avail[k] !== ea) begin errors++; $display("FAIL underrun_avail k=%0d got %0b exp %0b", k, obs_avail[k], ea); end
            checks++; if (obs_eu[k] !== eu) begin errors++; $display("FAIL underrun_flag k=%0d got %0b exp %0b", k, obs_eu[k], eu); end
            checks++; if (obs_done[k] !== (k == 39)) begin errors++; $display("FAIL underrun_done k=%0d got %0b exp %0b", k, obs_done[k], k == 39); end
            if (ea) begin
                logic [DS*DW-1:0] ex;
                ex = drop[k - 4] ? '0 : col(k - 1);
                checks++; if (obs_data[k] !== ex) begin errors++; $display("FAIL underrun_data k=%0d got %h exp %h", k, obs_data[k][7:0], ex[7:0]); end
            end
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        checks++; if (err_underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear got %0b exp 0", err_underrun); end
    endtask

    task automatic test_bypass;
        run_tile(2'd0, 32'h0000_FFFF, 1'b0, 64'd0, -2, 38);
        for (int k = 0; k < 38; k++) begin
            logic ea;
            ea = (k >= 4 && k <= 35);
            checks++; if (obs_avail[k] !== ea) begin errors++; $display("FAIL bypass_avail k=%0d got %0b exp %0b", k, obs_avail[k], ea); end
            checks++; if (obs_done[k] !== (k == 36)) begin errors++; $display("FAIL bypass_done k=%0d got %0b exp %0b", k, obs_done[k], k == 36); end
            checks++; if (obs_busy[k] !== (k >= 1 && k <= 36)) begin errors++; $display("FAIL bypass_busy k=%0d got %0b", k, obs_busy[k]); end
            checks++; if (obs_en[k] !== (k < 2)) begin errors++; $display("FAIL bypass_enable k=%0d got %0b exp %0b", k, obs_en[k], k < 2); end
            if (k >= 2) begin
                checks++; if (obs_mask[k] !== 32'h0000_FFFF) begin errors++; $display("FAIL bypass_mask k=%0d got %h exp 0000ffff", k, obs_mask[k]); end
            end
        end
    endtask

    task automatic test_timeout;
        run_tile(2'd2, '1, 1'b1, 64'd0, -1, 54);
        for (int k = 0; k < 54; k++) begin
            checks++; if (obs_done[k] !== (k == 51)) begin errors++; $display("FAIL timeout_done k=%0d got %0b exp %0b", k, obs_done[k], k == 51); end
            checks++; if (obs_et[k] !== (k >= 51)) begin errors++; $display("FAIL timeout_flag k=%0d got %0b exp %0b", k, obs_et[k], k >= 51); end
            checks++; if (obs_busy[k] !== (k >= 1 && k <= 51)) begin errors++; $display("FAIL timeout_busy k=%0d got %0b", k, obs_busy[k]); end
        end
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got %0b exp 0", err_timeout); end
    endtask

    task automatic test_back_to_back;
        cfg_wr_en = 1'b1; cfg_wr_addr = 2'd1; cfg_wr_mean = 8'h11; cfg_wr_inv_var = 8'h22;
        // rewrite entry 1 mid-STREAM and try a second start while busy
        run_tile(2'd1, '1, 1'b1, 64'd0, 38, 40, 10, 2'd1, 8'h33, 8'h44, 12);
        for (int k = 0; k < 40; k++) begin
            checks++; if (obs_done[k] !== (k == 39)) begin errors++; $display("FAIL midwr_done k=%0d got %0b exp %0b", k, obs_done[k], k == 39); end
            if (k >= 2) begin
                checks++; if (obs_mean[k] !== 8'h11 || obs_inv[k] !== 8'h22) begin errors++; $display("FAIL midwr_params k=%0d got %h/%h exp 11/22", k, obs_mean[k], obs_inv[k]); end
            end
        end
        // next tile starts in the first IDLE cycle: 40-cycle period
        run_tile(2'd1, '1, 1'b1, 64'd0, 38, 42);
        checks++; if (obs_busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got %0b exp 0", obs_busy[0]); end
        checks++; if (obs_mean[1] !== 8'h11) begin errors++; $display("FAIL b2b_hold got %h exp 11", obs_mean[1]); end
        for (int k = 0; k < 42; k++) begin
            checks++; if (obs_avail[k] !== (k >= 4 && k <= 35)) begin errors++; $display("FAIL b2b_avail k=%0d got %0b", k, obs_avail[k]); end
            checks++; if (obs_done[k] !== (k == 39)) begin errors++; $display("FAIL b2b_done k=%0d got %0b exp %0b", k, obs_done[k], k == 39); end
            if (k >= 2) begin
                checks++; if (obs_mean[k] !== 8'h33 || obs_inv[k] !== 8'h44) begin errors++; $display("FAIL b2b_params k=%0d got %h/%h exp 33/44", k, obs_mean[k], obs_inv[k]); end
            end
        end
    endtask

    task automatic test_write_with_start;
        run_tile(2'd3, '1, 1'b1, 64'd0, 38, 42, 0, 2'd3, 8'h5A, 8'hA5);
        checks++; if (obs_mean[2] !== 8'h5A || obs_inv[2] !== 8'hA5) begin errors++; $display("FAIL wrstart_params got %h/%h exp 5a/a5", obs_mean[2], obs_inv[2]); end
        checks++; if (obs_done[39] !== 1'b1) begin errors++; $display("FAIL wrstart_done got %0b exp 1", obs_done[39]); end
    endtask

    task automatic test_reset_mid;
        run_tile(2'd2, 32'h1234_5678, 1'b1, 64'd0, -1, 15);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || src_if.ready !== 1'b0 || norm_in_data_available !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got busy=%0b ready=%0b avail=%0b exp 000", busy, src_if.ready, norm_in_data_available); end
        checks++; if (norm_inp_data !== '0 || norm_validity_mask !== '0) begin errors++; $display("FAIL rstmid_data got %h/%h exp 0/0", norm_inp_data[7:0], norm_validity_mask); end
        checks++; if (norm_mean !== 8'h00 || norm_enable !== 1'b0) begin errors++; $display("FAIL rstmid_params got %h/%0b exp 00/0", norm_mean, norm_enable); end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_quiet i=%0d got done=%0b busy=%0b exp 0/0", i, done, busy); end
        end
        // table was cleared, so entry 2 now reads zero
        cfg_wr_en = 1'b1; cfg_wr_addr = 2'd0; cfg_wr_mean = 8'h77; cfg_wr_inv_var = 8'h66;
        run_tile(2'd2, '1, 1'b1, 64'd0, 38, 42);
        for (int k = 0; k < 42; k++) begin
            checks++; if (obs_avail[k] !== (k >= 4 && k <= 35)) begin errors++; $display("FAIL rstmid_avail k=%0d got %0b", k, obs_avail[k]); end
            checks++; if (obs_done[k] !== (k == 39)) begin errors++; $display("FAIL rstmid_done k=%0d got %0b exp %0b", k, obs_done[k], k == 39); end
        end
        checks++; if (obs_mean[2] !== 8'h00 || obs_inv[2] !== 8'h00) begin errors++; $display("FAIL rstmid_table got %h/%h exp 00/00", obs_mean[2], obs_inv[2]); end
    endtask

    initial begin
        reset = 1'b1;
        cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_mean = '0; cfg_wr_inv_var = '0;
        start = 1'b0; ch_sel = '0; mask_in = '0; enable_in = 1'b0;
        src_if.valid = 1'b0; src_if.data = '0;
        norm_done = 1'b0; err_clr = 1'b0;

        test_reset;
        test_basic;
        test_underrun;
        test_bypass;
        test_timeout;
        test_back_to_back;
        test_write_with_start;
        test_reset_mid;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
